// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Brief    : Memory-side responder for the core load/store port. Accepts
//             one request at a time over valid/ready, performs byte/half/word
//             lane writes and sign/zero-extended loads, and exposes a
//             memory-mapped test register. Optional wait states delay the
//             response.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] TEST_ADDR   = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] test
);

    localparam int          c_IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_ARRAY_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  c_WAIT_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0]  c_IDLE = 2'd0;
    localparam logic [1:0]  c_WAIT = 2'd1;
    localparam logic [1:0]  c_RESP = 2'd2;

    localparam logic [1:0]  c_SZ_BYTE = 2'b00;
    localparam logic [1:0]  c_SZ_HALF = 2'b01;
    localparam logic [1:0]  c_SZ_WORD = 2'b10;
    localparam logic [1:0]  c_SZ_ILL  = 2'b11;

    // Storage array: deliberately not cleared by reset.
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic [1:0]         r_state;
    logic [3:0]         r_cnt;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [31:0]        r_test;

    logic               w_accept;
    logic               w_in_array;
    logic               w_is_test;
    logic               w_misaligned;
    logic               w_err;
    logic               w_do_write;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_data;
    logic [31:0]        w_wdata_rep;
    logic [3:0]         w_be;

    assign w_accept = req_valid && r_req_ready;
    assign w_idx    = req_addr[c_IDX_W+1:2];

    // Address decode and error classification for the presented request.
    always_comb begin
        w_in_array   = (req_addr < c_ARRAY_BYTES);
        w_is_test    = (req_addr == TEST_ADDR);
        w_misaligned = ((req_size == c_SZ_HALF) && req_addr[0]) ||
                       ((req_size == c_SZ_WORD) && (req_addr[1:0] != 2'b00));
        w_err        = (req_size == c_SZ_ILL) ||
                       w_misaligned ||
                       !(w_in_array || w_is_test) ||
                       (w_is_test && (req_size != c_SZ_WORD));
        w_do_write   = w_accept && req_we && !w_err && w_in_array && !reset;
    end

    // Load path: pick source word, select lane(s), then extend.
    always_comb begin
        w_word      = w_is_test ? r_test : r_mem[w_idx];
        w_byte      = w_word[7:0];
        w_half      = req_addr[1] ? w_word[31:16] : w_word[15:0];
        w_load_data = w_word;
        case (req_addr[1:0])
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        case (req_size)
            c_SZ_BYTE: w_load_data = req_unsigned ? {24'd0, w_byte}
                                                  : {{24{w_byte[7]}}, w_byte};
            c_SZ_HALF: w_load_data = req_unsigned ? {16'd0, w_half}
                                                  : {{16{w_half[15]}}, w_half};
            default:   w_load_data = w_word;
        endcase
    end

    // Store path: replicate right-justified data across lanes and build byte enables.
    always_comb begin
        w_wdata_rep = req_wdata;
        w_be        = 4'b1111;
        case (req_size)
            c_SZ_BYTE: begin
                w_wdata_rep = {4{req_wdata[7:0]}};
                w_be        = 4'b0001 << req_addr[1:0];
            end
            c_SZ_HALF: begin
                w_wdata_rep = {2{req_wdata[15:0]}};
                w_be        = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata_rep = req_wdata;
                w_be        = 4'b1111;
            end
        endcase
    end

    // Byte-lane write into the storage array on the accept edge.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
                end
            end
        end
    end

    // Handshake FSM with registered outputs, read capture and test register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
            r_test      <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_err       <= w_err;
                        r_rdata     <= (w_err || req_we) ? 32'd0 : w_load_data;
                        r_req_ready <= 1'b0;
                        if (req_we && !w_err && w_is_test) begin
                            r_test <= req_wdata;
                        end
                        if (WAIT_STATES > 0) begin
                            r_state <= c_WAIT;
                            r_cnt   <= c_WAIT_LOAD;
                        end else begin
                            r_state     <= c_RESP;
                            r_rsp_valid <= 1'b1;
                        end
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= c_RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    // rdata/err are left untouched so they hold under backpressure.
                    if (rsp_ready) begin
                        r_state     <= c_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign test      = r_test;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Brief    : Self-checking bench for data_mem_responder. Two instances, one
//             without wait states and one with three, are driven from a
//             byte-array reference model of memory and the test register.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam logic [31:0] c_TEST_ADDR = 32'h0000_0100;

    logic        clk;
    logic        reset        [2];
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [31:0] req_addr     [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [31:0] rsp_rdata    [2];
    logic        rsp_err      [2];
    logic [31:0] test         [2];

    int          n_err = 0;
    int          n_chk = 0;
    bit          chk_en = 0;
    bit          exp_pend [2];
    bit          exp_err  [2];
    logic [31:0] exp_rd   [2];
    logic [31:0] model_test [2];
    logic [7:0]  model_mem  [2][256];

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0), .TEST_ADDR(c_TEST_ADDR)) u_dut0 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .test(test[0])
    );

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3), .TEST_ADDR(c_TEST_ADDR)) u_dut1 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .test(test[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_states(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
        end
    endtask

    // Reference model: outcome of a request from the current model state.
    function automatic void model_eval(input int d, input bit we, input logic [31:0] a,
                                       input logic [1:0] sz, input bit u,
                                       output bit e, output logic [31:0] rd);
        int          n;
        logic [31:0] v;
        bit          is_test;
        bit          in_arr;
        n       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        is_test = (a == c_TEST_ADDR);
        in_arr  = (a < 32'd256);
        e  = (sz == 2'd3) || ((a % n) != 0) || !(is_test || in_arr) || (is_test && sz != 2'd2);
        rd = 32'd0;
        if (!e && !we) begin
            if (is_test) begin
                v = model_test[d];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(model_mem[d][a + i]) << (8 * i));
                if (n < 4 && !u && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            end
            rd = v;
        end
    endfunction

    function automatic void model_apply(input int d, input bit we, input logic [31:0] a,
                                        input logic [1:0] sz, input logic [31:0] wd, input bit e);
        int n;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (we && !e) begin
            if (a == c_TEST_ADDR) model_test[d] = wd;
            else for (int i = 0; i < n; i++) model_mem[d][a + i] = wd[8*i +: 8];
        end
    endfunction

    // Compare process: every cycle, outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("test_reg[%0d]", d), test[d], model_test[d]);
                    if (rsp_valid[d]) begin
                        if (!exp_pend[d]) begin
                            chk($sformatf("spurious_rsp_valid[%0d]", d), 32'(rsp_valid[d]), 32'd0);
                        end else begin
                            chk($sformatf("rsp_rdata[%0d]", d), rsp_rdata[d], exp_rd[d]);
                            chk($sformatf("rsp_err[%0d]", d), 32'(rsp_err[d]), 32'(exp_err[d]));
                            chk($sformatf("req_ready_busy[%0d]", d), 32'(req_ready[d]), 32'd0);
                        end
                    end
                end
            end
        end
    end

    // One complete transaction: request, latency check, optional backpressure, handshake.
    task automatic do_req(input int d, input bit we, input logic [31:0] a, input logic [1:0] sz,
                          input bit u, input logic [31:0] wd, input int hold,
                          output bit g_err, output logic [31:0] g_rd);
        bit          e;
        logic [31:0] rd;
        int          k;
        model_eval(d, we, a, sz, u, e, rd);
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a;
        req_size[d] = sz; req_unsigned[d] = u; req_wdata[d] = wd;
        k = 0;
        while (!req_ready[d] && k < 50) begin @(negedge clk); k++; end
        if (!req_ready[d]) chk("req_ready_timeout", 32'(req_ready[d]), 32'd1);
        exp_err[d] = e; exp_rd[d] = rd; exp_pend[d] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        model_apply(d, we, a, sz, wd, e);
        k = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid[d] || k >= 40) break;
            k++;
        end
        chk($sformatf("latency[%0d]", d), k, wait_states(d));
        g_err = rsp_err[d];
        g_rd  = rsp_rdata[d];
        repeat (hold) @(negedge clk);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        exp_pend[d]  = 1'b0;
        chk($sformatf("idle_rsp_valid[%0d]", d), 32'(rsp_valid[d]), 32'd0);
        chk($sformatf("idle_req_ready[%0d]", d), 32'(req_ready[d]), 32'd1);
    endtask

    task automatic dir(input int d, input bit we, input logic [31:0] a, input logic [1:0] sz,
                       input bit u, input logic [31:0] wd, input int hold, input string name,
                       input logic [31:0] lit_rd, input bit lit_err);
        bit          ge;
        logic [31:0] gr;
        do_req(d, we, a, sz, u, wd, hold, ge, gr);
        chk({name, "_rdata"}, gr, lit_rd);
        chk({name, "_err"}, 32'(ge), 32'(lit_err));
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 6))
            0, 1:    return 32'($urandom_range(0, 255));
            2:       return 32'($urandom_range(0, 63) * 4);
            3:       return c_TEST_ADDR + 32'($urandom_range(0, 3));
            4:       return $urandom;
            5:       return c_TEST_ADDR + 32'($urandom_range(1, 40) * 4);
            default: return 32'h0001_0000 | 32'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ge;
        logic [31:0] gr;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
            req_size[d] = 2'd0; req_unsigned[d] = 1'b0; req_wdata[d] = 32'd0;
            rsp_ready[d] = 1'b0; exp_pend[d] = 1'b0; exp_err[d] = 1'b0; exp_rd[d] = 32'd0;
            model_test[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_req_ready[%0d]", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("rst_rsp_valid[%0d]", d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("rst_rsp_rdata[%0d]", d), rsp_rdata[d], 32'd0);
            chk($sformatf("rst_rsp_err[%0d]", d), 32'(rsp_err[d]), 32'd0);
            chk($sformatf("rst_test[%0d]", d), test[d], 32'd0);
            reset[d] = 1'b0;
        end
        chk_en = 1'b1;

        // Fill both arrays so every later load has a defined expectation.
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++)
                do_req(d, 1'b1, 32'(w * 4), 2'd2, 1'b0, $urandom, 0, ge, gr);

        // Directed: no wait states.
        dir(0, 1, 32'h10, 2'd2, 0, 32'hDEADBEEF, 0, "st_word", 32'h0, 0);
        dir(0, 0, 32'h10, 2'd2, 0, 32'h0, 0, "ld_word", 32'hDEADBEEF, 0);
        dir(0, 1, 32'h12, 2'd0, 0, 32'h12345680, 0, "st_byte", 32'h0, 0);
        dir(0, 0, 32'h10, 2'd2, 0, 32'h0, 1, "ld_word_lane", 32'hDE80BEEF, 0);
        dir(0, 0, 32'h12, 2'd0, 0, 32'h0, 0, "ld_byte_s", 32'hFFFFFF80, 0);
        dir(0, 0, 32'h12, 2'd0, 1, 32'h0, 0, "ld_byte_u", 32'h00000080, 0);
        dir(0, 0, 32'h12, 2'd1, 0, 32'h0, 0, "ld_half_s", 32'hFFFFDE80, 0);
        dir(0, 0, 32'h11, 2'd1, 0, 32'h0, 0, "err_half_mis", 32'h0, 1);
        dir(0, 0, 32'h102, 2'd2, 0, 32'h0, 0, "err_word_mis", 32'h0, 1);
        dir(0, 0, 32'h200, 2'd2, 0, 32'h0, 0, "err_range", 32'h0, 1);
        dir(0, 1, 32'h10, 2'd3, 0, 32'h11111111, 0, "err_size", 32'h0, 1);
        dir(0, 1, 32'h1_0010, 2'd2, 0, 32'h22222222, 0, "err_alias", 32'h0, 1);
        dir(0, 0, 32'h10, 2'd2, 0, 32'h0, 0, "reread", 32'hDE80BEEF, 0);
        dir(0, 1, 32'h100, 2'd2, 0, 32'h000000A5, 0, "st_test", 32'h0, 0);
        chk("test_after_store", test[0], 32'h000000A5);
        dir(0, 0, 32'h100, 2'd2, 0, 32'h0, 0, "ld_test", 32'h000000A5, 0);
        dir(0, 1, 32'h100, 2'd0, 0, 32'h000000FF, 0, "err_test_byte", 32'h0, 1);
        chk("test_unchanged", test[0], 32'h000000A5);

        // Directed: three wait states with backpressure.
        dir(1, 1, 32'h10, 2'd2, 0, 32'hDEADBEEF, 0, "w3_st_word", 32'h0, 0);
        dir(1, 0, 32'h10, 2'd2, 0, 32'h0, 5, "w3_ld_hold", 32'hDEADBEEF, 0);

        // Reset while the request sits in WAIT.
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h10; req_size[1] = 2'd2;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        reset[1] = 1'b1;
        @(posedge clk);
        #1;
        reset[1] = 1'b0;
        model_test[1] = 32'd0;
        chk("midrst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("midrst_req_ready", 32'(req_ready[1]), 32'd1);
        chk("midrst_test", test[1], 32'd0);
        repeat (6) @(negedge clk);
        chk("midrst_no_rsp", 32'(rsp_valid[1]), 32'd0);
        dir(1, 0, 32'h10, 2'd2, 0, 32'h0, 0, "midrst_reload", 32'hDEADBEEF, 0);

        // Randomized traffic on both instances.
        for (int d = 0; d < 2; d++)
            for (int t = 0; t < 300; t++)
                do_req(d, 1'($urandom_range(0, 1)), rand_addr(), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), ge, gr);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
